// File: rtl/dm_pkg.sv
// ============================================================================
// dm_pkg : shared size encodings, FSM state type and byte-lane helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Byte-lane enables for an already aligned offset.
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] en;
    en = 4'b1111;
    case (size)
      SZ_BYTE: en = 4'b0001 << off;
      SZ_HALF: en = off[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_ram.sv
// ============================================================================
// dm_ram : 2^ADDR_W x 32 synchronous array, byte write enables, registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module dm_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/dm_resp.sv
// ============================================================================
// dm_resp : data-memory responder, req/ack handshake, byte/half/word lanes.
// Optional: DM_RESP_MISALIGN_EN reports misaligned/reserved accesses as errors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dm_resp
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t             state, state_nxt;
  logic               accept;
  logic               bad;
  logic [1:0]         size_in;
  logic               hold_we;
  logic [1:0]         hold_size;
  logic               hold_sign;
  logic [ADDR_W+1:0]  hold_addr;
  logic [31:0]        hold_wdata;
  logic [3:0]         wait_cnt;
  logic [1:0]         off;
  logic [ADDR_W-1:0]  ram_addr;
  logic [3:0]         ram_we;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;
  logic [31:0]        load_fmt;
  logic [31:0]        shifted;
  logic [15:0]        half;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W+2];
  assign accept  = (state == ST_IDLE) && req;
  assign size_in = (size == SZ_RSVD) ? SZ_WORD : size;

`ifdef DM_RESP_MISALIGN_EN
  logic err_q;
  assign bad = ((size == SZ_HALF) && addr[0]) ||
               ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
               (size == SZ_RSVD);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        err_q <= 1'b0;
    else if (accept) err_q <= bad;
  end
  assign err = err_q;
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (bad)                  state_nxt = ST_RESP;
          else if (WAIT_CYCLES > 0) state_nxt = ST_WAIT;
          else                      state_nxt = ST_ACCESS;
        end
      end
      ST_WAIT:   if (wait_cnt == 4'd0) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign ack  = (state == ST_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_we    <= 1'b0;
      hold_size  <= SZ_BYTE;
      hold_sign  <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (accept) begin
      hold_we    <= we;
      hold_size  <= size_in;
      hold_sign  <= sign;
      hold_addr  <= addr[ADDR_W+1:0];
      hold_wdata <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           wait_cnt <= 4'd0;
    else if (accept)                                    wait_cnt <= WAIT_INIT;
    else if ((state == ST_WAIT) && (wait_cnt != 4'd0))  wait_cnt <= wait_cnt - 4'd1;
  end

  // Low offset bits forced to the natural alignment of the access size.
  always_comb begin
    off = hold_addr[1:0];
    case (hold_size)
      SZ_HALF: off = {hold_addr[1], 1'b0};
      SZ_WORD: off = 2'b00;
      default: off = hold_addr[1:0];
    endcase
  end

  // Array address comes straight from the request in IDLE so the registered
  // read word is already valid during ACCESS.
  assign ram_addr = (state == ST_IDLE) ? addr[ADDR_W+1:2] : hold_addr[ADDR_W+1:2];
  assign ram_we   = ((state == ST_ACCESS) && hold_we) ? lane_en(hold_size, off) : 4'b0000;

  always_comb begin
    ram_wdata = hold_wdata;
    case (hold_size)
      SZ_BYTE: ram_wdata = {4{hold_wdata[7:0]}};
      SZ_HALF: ram_wdata = {2{hold_wdata[15:0]}};
      default: ram_wdata = hold_wdata;
    endcase
  end

  dm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    shifted  = ram_rdata >> {off, 3'b000};
    half     = off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_fmt = ram_rdata;
    case (hold_size)
      SZ_BYTE: load_fmt = {{24{hold_sign & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_fmt = {{16{hold_sign & half[15]}}, half};
      default: load_fmt = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 rdata <= 32'd0;
    else if (accept && bad)                   rdata <= 32'd0;
    else if ((state == ST_ACCESS) && !hold_we) rdata <= load_fmt;
  end

endmodule

`default_nettype wire

// File: doc/dm_resp.md
# dm_resp

Data-memory responder: the memory-side end of the CPU's data-access interface. Accepts one load/store request at a time over a req/ack handshake, performs byte, halfword or word access with byte lanes, sign/zero-extends load data, and returns a single-cycle acknowledge. It replaces the bare word-only data memory behind the multi-cycle core so that lb/lbu/lh/lhu/sb/sh can be executed.

## Interface
- ADDR_W, 10: word-address width; array depth 2^ADDR_W words (4 KB default)
- WAIT_CYCLES, 0: extra wait states inserted before every array access (0..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  request strobe, sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- sign  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- busy  out  1  high in every state except IDLE
- ack  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid while ack=1; held until next ack
- err  out  1  error flag, valid while ack=1

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: req=1 captures we, size, sign, addr, wdata into holding registers; next state WAIT if WAIT_CYCLES>0 else ACCESS. req outside IDLE ignored; requester need not hold inputs after acceptance.
- WAIT: down-counter loaded with WAIT_CYCLES-1 on accept; leaves to ACCESS when counter is 0.
- ACCESS: one array cycle. Store: byte enables written at the exiting edge. Load: word read and formatted into rdata at the exiting edge. Next state RESP.
- RESP: ack=1, err valid; next state IDLE unconditionally. Back-to-back request possible one cycle after RESP.
- Word index = addr[ADDR_W+1:2]; higher address bits ignored (addresses wrap modulo 2^(ADDR_W+2)).
- Little-endian lanes: byte offset k occupies word bits [8k+7:8k]; half at offset 0 uses [15:0], offset 2 uses [31:16].
- Store replicates: byte -> lane addr[1:0] only; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four.
- Load: selected byte/half right-justified, extended per sign; word passes through, sign ignored.
- Array contents are not reset; undefined until written.

## Timing
- Reset (rst=0): state IDLE, busy 0, ack 0, rdata 0, err 0, wait counter 0; takes effect immediately.
- Request accepted at edge E (req=1, IDLE): ack high in cycle E+2+WAIT_CYCLES; busy high from E+1 through the ack cycle.
- Throughput: one access per 3+WAIT_CYCLES cycles.
- Store commits at the ACCESS exit edge; a load issued afterwards returns the new data.
- Reset asserted before the ACCESS exit edge aborts the access with no array write and no ack; reset at or after it leaves the write committed but suppresses ack.

## Configuration
- DM_RESP_MISALIGN_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size=11 is an error. Accept goes straight to RESP (skips WAIT/ACCESS), no array write, rdata=0, err=1 with ack one cycle after accept.
- Undefined: low address bits forced to alignment (half clears bit 0, word clears bits 1:0), size=11 treated as word, err tied 0.

## Structure
- Shared package dm_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, lane-enable function.
- One sub-module dm_ram: 2^ADDR_W x 32 synchronous array with 4-bit byte write enable and registered read.
- FSM, wait counter, lane steering and load extension live in dm_resp.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load 0x10 -> rdata 0xDEADBEEF, err 0, ack exactly 2 cycles after accept (WAIT_CYCLES=0).
- Byte store 0x80 at 0x13 over word 0x00000000, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80000000.
- Half store 0x1234 at 0x22, lh 0x22 -> 0x00001234; lw 0x20 -> 0x12340000 with lower half unchanged.
- WAIT_CYCLES=3: ack at accept+5; req pulses while busy=1 produce no extra ack and no array write.
- With DM_RESP_MISALIGN_EN: sw at 0x41 -> ack at accept+1, err 1, rdata 0, lw 0x40 unchanged; without macro same sw writes word 0x40.
- rst low during WAIT of a store: ack never asserts, busy 0, subsequent load of that address returns prior contents.
